sample_pingpong_buffer: RTL and testbench

Dual-bank sample store between the XADC controller and `signal_Drawer`. Incoming scaled samples fill one BRAM bank while `signal_Drawer` reads the other by column address `ADD`. Banks swap whenever the drawer toggles `activeBRAMselect` at the last visible pixel. The result is one stable trace per frame and no tearing.

---
 rtl/sample_pingpong_buffer.sv | 160 ++++++++++++++++
 tb/tb_sample_pingpong_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_pingpong_buffer.sv
// rtl/sample_pingpong_buffer.sv - dual-bank sample store: writer fills one bank while the drawer reads the other.
// Optional rising-edge trigger with timeout fallback is enabled by defining SAMPLE_TRIGGER_EN.
module sample_pingpong_buffer #(
  parameter int SAMPLE_WIDTH  = 12,
  parameter int ADD_SIZE      = 11,
  parameter int DEPTH         = 1280,
  parameter int TRIGGER_LEVEL = 0,
  parameter int TRIG_TIMEOUT  = 4096
) (
  input  logic                           CLK104MHZ,
  input  logic                           RST,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid,
  input  logic                           activeBRAMselect,
  input  logic        [ADD_SIZE-1:0]     ADD,
  output logic signed [SAMPLE_WIDTH-1:0] ADC_OUT,
  output logic                           frame_ready,
  output logic                           underfill,
  output logic                           overrun
);

  localparam logic [ADD_SIZE-1:0] LAST_ADDR = ADD_SIZE'(DEPTH - 1);
  localparam logic [ADD_SIZE:0]   DEPTH_EXT = (ADD_SIZE + 1)'(DEPTH);
  localparam logic signed [SAMPLE_WIDTH-1:0] LEVEL = SAMPLE_WIDTH'(TRIGGER_LEVEL);
  localparam logic [12:0] TIMEOUT_LAST = 13'(TRIG_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  logic signed [SAMPLE_WIDTH-1:0] bank0 [0:DEPTH-1];
  logic signed [SAMPLE_WIDTH-1:0] bank1 [0:DEPTH-1];

  state_t              state;
  logic [ADD_SIZE-1:0] wr_addr;
  logic                sel_q;
  logic                swap;
  logic                take;
  logic                trigger;
  logic                wr_en;
  logic [ADD_SIZE-1:0] wr_ptr;

  // A swap in the same cycle as a valid sample discards that sample entirely.
  assign swap = activeBRAMselect ^ sel_q;
  assign take = sample_valid & ~swap;

`ifdef SAMPLE_TRIGGER_EN
  logic signed [SAMPLE_WIDTH-1:0] prev;
  logic [12:0]                    timeout_cnt;

  assign trigger = ((prev < LEVEL) && (sample_in >= LEVEL)) ||
                   (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge CLK104MHZ or posedge RST) begin
    if (RST) begin
      prev        <= '0;
      timeout_cnt <= '0;
    end else begin
      if (take) begin
        prev <= sample_in;
      end
      if (swap || state != ARM) begin
        timeout_cnt <= '0;
      end else if (take) begin
        timeout_cnt <= timeout_cnt + 13'd1;
      end
    end
  end
`else
  logic unused_trigger_cfg;

  assign trigger            = 1'b1;
  assign unused_trigger_cfg = ^{LEVEL, TIMEOUT_LAST};
`endif

  always_comb begin
    wr_en  = 1'b0;
    wr_ptr = wr_addr;
    case (state)
      ARM: begin
        wr_en  = take & trigger;
        wr_ptr = '0;
      end
      FILL: begin
        wr_en = take;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK104MHZ or posedge RST) begin
    if (RST) begin
      state       <= ARM;
      wr_addr     <= '0;
      sel_q       <= 1'b0;
      frame_ready <= 1'b0;
      underfill   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sel_q     <= activeBRAMselect;
      underfill <= 1'b0;
      if (swap) begin
        state       <= ARM;
        wr_addr     <= '0;
        frame_ready <= 1'b0;
        overrun     <= 1'b0;
        underfill   <= (state != FULL);
      end else if (take) begin
        case (state)
          ARM: begin
            if (trigger) begin
              wr_addr <= ADD_SIZE'(1);
              state   <= FILL;
            end
          end
          FILL: begin
            // The last slot parks the pointer; the writer holds until the next swap.
            if (wr_addr == LAST_ADDR) begin
              state       <= FULL;
              frame_ready <= 1'b1;
            end else begin
              wr_addr <= wr_addr + ADD_SIZE'(1);
            end
          end
          FULL: begin
            overrun <= 1'b1;
          end
          default: begin
            state <= ARM;
          end
        endcase
      end
    end
  end

  // Write bank is the complement of the drawer's read bank.
  always_ff @(posedge CLK104MHZ) begin
    if (wr_en && activeBRAMselect) begin
      bank0[wr_ptr] <= sample_in;
    end
    if (wr_en && !activeBRAMselect) begin
      bank1[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge CLK104MHZ or posedge RST) begin
    if (RST) begin
      ADC_OUT <= '0;
    end else if ({1'b0, ADD} < DEPTH_EXT) begin
      ADC_OUT <= activeBRAMselect ? bank1[ADD] : bank0[ADD];
    end else begin
      ADC_OUT <= '0;
    end
  end

endmodule

// File: tb/tb_sample_pingpong_buffer.sv
// tb/tb_sample_pingpong_buffer.sv - randomized scoreboard bench for sample_pingpong_buffer.
module tb_sample_pingpong_buffer;

  localparam int DEPTH = 1280;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] sample_in;
  logic               sample_valid;
  logic               sel;
  logic [10:0]        add;
  logic signed [11:0] adc_out;
  logic               frame_ready;
  logic               underfill;
  logic               overrun;

  sample_pingpong_buffer dut (
    .CLK104MHZ       (clk),
    .RST             (rst),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .activeBRAMselect(sel),
    .ADD             (add),
    .ADC_OUT         (adc_out),
    .frame_ready     (frame_ready),
    .underfill       (underfill),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    bit   chk_adc;
    int   adc;
    bit   fr;
    bit   ov;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   uf_cnt = 0;

  // Reference model: bank images plus "samples taken since the last swap".
  int   mbank [2][DEPTH];
  bit   mok   [2][DEPTH];
  int   n_taken = 0;
  bit   m_ovr = 0;
  bit   m_selq = 0;
  int   m_prev = 0;
  int   m_tcnt = 0;
  bit   cur = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (underfill) uf_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk("frame_ready", int'(frame_ready), int'(e.fr));
      chk("overrun", int'(overrun), int'(e.ov));
      if (e.chk_adc) chk("ADC_OUT", int'(adc_out), e.adc);
    end
  end

  task automatic model_take(input int d, input int wb);
    bit trig;
    if (n_taken == 0) begin
`ifdef SAMPLE_TRIGGER_EN
      m_tcnt++;
      trig = (m_prev < 0 && d >= 0) || (m_tcnt == 4096);
`else
      trig = 1;
`endif
      if (trig) begin
        mbank[wb][0] = d;
        mok[wb][0]   = 1;
        n_taken      = 1;
        m_tcnt       = 0;
      end
    end else if (n_taken < DEPTH) begin
      mbank[wb][n_taken] = d;
      mok[wb][n_taken]   = 1;
      n_taken++;
    end else begin
      m_ovr = 1;
    end
    m_prev = d;
  endtask

  // Drive one clock: inputs applied at the falling edge, expectation queued for after the rising edge.
  task automatic step(input bit v, input int d, input bit s, input int a);
    exp_t e;
    int   sd;
    sd           = int'($signed(12'(d)));
    sample_valid = v;
    sample_in    = 12'(d);
    sel          = s;
    add          = 11'(a);
    e.cyc        = cyc + 1;
    if (a < DEPTH) begin
      e.chk_adc = mok[s][a];
      e.adc     = mbank[s][a];
    end else begin
      e.chk_adc = 1;
      e.adc     = 0;
    end
    if (s != m_selq) begin
      n_taken = 0;
      m_ovr   = 0;
      m_tcnt  = 0;
    end else if (v) begin
      model_take(sd, s ? 0 : 1);
    end
    m_selq = s;
    e.fr   = (n_taken == DEPTH);
    e.ov   = m_ovr;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int rnd_add();
    return int'($urandom_range(0, 1400));
  endfunction

  task automatic prime();
`ifdef SAMPLE_TRIGGER_EN
    step(1, -1, cur, rnd_add());
`endif
  endtask

  task automatic fill(input int count, input int base, input bit rnd);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 2) == 0) step(0, int'($urandom), cur, rnd_add());
      step(1, rnd ? int'($urandom_range(0, 4095)) : base + i, cur, rnd_add());
    end
  endtask

  task automatic toggle(input int exp_uf);
    int u0;
    u0  = uf_cnt;
    cur = ~cur;
    step(0, 0, cur, rnd_add());
    repeat (3) step(0, 0, cur, rnd_add());
    chk("underfill_pulses", uf_cnt - u0, exp_uf);
  endtask

  task automatic read_chk(input string nm, input int a, input int exp);
    step(0, 0, cur, a);
    chk(nm, int'(adc_out), exp);
  endtask

  initial begin
    int u0;
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    sel          = 1'b0;
    add          = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_adc", int'(adc_out), 0);
    chk("reset_frame_ready", int'(frame_ready), 0);
    chk("reset_underfill", int'(underfill), 0);
    chk("reset_overrun", int'(overrun), 0);

    // Full frame of index values, then overrun, then a clean swap.
    prime();
    fill(DEPTH, 0, 0);
    chk("full_frame_ready", int'(frame_ready), 1);
    repeat (3) step(1, int'($urandom_range(0, 4095)), cur, rnd_add());
    chk("overrun_set", int'(overrun), 1);
    toggle(0);
    chk("swap_clears_overrun", int'(overrun), 0);
    chk("swap_clears_frame_ready", int'(frame_ready), 0);
    read_chk("read_addr5", 5, 5);
    read_chk("read_addr1279", 1279, 1279);
    read_chk("read_out_of_range", 1300, 0);

    // Early swap after 600 samples.
    prime();
    fill(600, 0, 1);
    toggle(1);
    prime();
    step(1, 12'h155, cur, rnd_add());

    // Swap coinciding with a valid sample: the sample is dropped.
    u0  = uf_cnt;
    cur = ~cur;
    step(1, 12'h7FF, cur, rnd_add());
    prime();
    step(1, 12'h010, cur, rnd_add());
    chk("swap_valid_underfill", uf_cnt - u0, 1);
    read_chk("early_swap_addr0", 0, 12'h155);
    fill(DEPTH - 1, 0, 1);
    chk("refill_frame_ready", int'(frame_ready), 1);
    toggle(0);
    read_chk("dropped_sample_addr0", 0, 12'h010);

    // Reset in the middle of a fill.
    prime();
    fill(700, 0, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_adc", int'(adc_out), 0);
    chk("midreset_frame_ready", int'(frame_ready), 0);
    chk("midreset_underfill", int'(underfill), 0);
    chk("midreset_overrun", int'(overrun), 0);
    sbq.delete();
    n_taken = 0;
    m_ovr   = 0;
    m_selq  = 0;
    m_prev  = 0;
    m_tcnt  = 0;
    @(negedge clk);
    rst = 1'b0;
    prime();
    fill(5, 12'h2A0, 0);
    toggle(1);
    read_chk("restart_addr0", 0, 12'h2A0);
    read_chk("restart_addr4", 4, 12'h2A4);
    for (int i = 0; i < 40; i++) step(0, 0, cur, rnd_add());

`ifdef SAMPLE_TRIGGER_EN
    step(1, -5, cur, rnd_add());
    step(1, -3, cur, rnd_add());
    step(1, 2, cur, rnd_add());
    fill(20, 0, 1);
    toggle(1);
    read_chk("trigger_addr0", 0, 2);
    for (int i = 0; i < 4095; i++) step(1, -100, cur, rnd_add());
    for (int i = 0; i < DEPTH - 1; i++) step(1, -100, cur, rnd_add());
    chk("timeout_not_full_yet", int'(frame_ready), 0);
    step(1, -100, cur, rnd_add());
    chk("timeout_full", int'(frame_ready), 1);
`endif

    step(0, 0, cur, rnd_add());
    step(0, 0, cur, rnd_add());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
